oam_dma_arbiter: RTL

- NES sprite (OAM) DMA engine and system-bus arbiter between the CPU core and the DMA.
- A CPU write to DMA_TRIG_ADDR latches a source page, halts the CPU through cpu_rdy, and takes the bus.
- Copies 256 bytes from {page,8'h00}..{page,8'hFF} to OAM_DATA_ADDR using alternating read/write cycles, then returns the bus to the CPU.
- Sits between the CPU address/data ports and the system bus decoder.

---
 rtl/oam_dma_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/oam_dma_arbiter.sv
// Sprite (OAM) DMA engine and CPU/DMA system-bus arbiter.
// A CPU write to DMA_TRIG_ADDR halts the core and copies one 256-byte page to OAM_DATA_ADDR.
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_TRIG_ADDR = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_wr,
  output logic        cpu_rdy,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_wr,
  input  logic [7:0]  bus_rdata,
  output logic        dma_active,
  output logic [2:0]  dbg_state,
  output logic [7:0]  dbg_idx
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t      state;
  logic        parity;
  logic [7:0]  idx;
  logic [7:0]  page;
  logic [7:0]  data;

  // cpu_rdy is a ready toward the core: while it is 0 the core holds every
  // input steady and none of its write strobes reach the bus.
  always_ff @(posedge clk_ph1) begin
    if (!rst) begin
      state      <= IDLE;
      parity     <= 1'b0;
      idx        <= 8'h00;
      page       <= 8'h00;
      data       <= 8'h00;
      cpu_rdy    <= 1'b1;
      dma_active <= 1'b0;
    end else begin
      parity <= ~parity;
      case (state)
        IDLE: begin
          if (cpu_wr && (cpu_addr == DMA_TRIG_ADDR)) begin
            page       <= cpu_wdata;
            idx        <= 8'h00;
            cpu_rdy    <= 1'b0;
            dma_active <= 1'b1;
            state      <= HALT;
          end
        end
        // Reads must land on get cycles, so insert ALIGN when the next cycle is a put.
        HALT:  state <= parity ? READ : ALIGN;
        ALIGN: state <= READ;
        READ: begin
          data  <= bus_rdata;
          state <= WRITE;
        end
        WRITE: begin
          if (idx == 8'hFF) begin
            idx        <= 8'h00;
            cpu_rdy    <= 1'b1;
            dma_active <= 1'b0;
            state      <= IDLE;
          end else begin
            idx   <= idx + 8'h01;
            state <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus_addr  = cpu_addr;
    bus_wdata = cpu_wdata;
    bus_wr    = 1'b0;
    case (state)
      IDLE:  bus_wr = cpu_wr;
      READ:  begin
        bus_addr  = {page, idx};
        bus_wdata = data;
      end
      WRITE: begin
        bus_addr  = OAM_DATA_ADDR;
        bus_wdata = data;
        bus_wr    = 1'b1;
      end
      default: bus_wr = 1'b0;
    endcase
  end

  assign dbg_state = state;
  assign dbg_idx   = idx;

endmodule
